// File: rtl/thread_pc_controller.sv
// Round-robin barrel PC issuer: one thread per cycle, each thread's next PC chosen when its previous PC returns.
// Outputs registered; return-to-reissue is one cycle. No backpressure: IO_ready low makes the thread repeat its PC.
module thread_pc_controller #(
  parameter int PC_WIDTH          = 10,
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = 3,
  parameter int INITIAL_THREAD    = 0,
  parameter int START_PC          = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         jump,
  input  logic [PC_WIDTH-1:0]          branch_destination,
  input  logic                         IO_ready,
  output logic [PC_WIDTH-1:0]          PC,
  output logic [THREAD_ADDR_WIDTH-1:0] thread,
  output logic                         reissue
);

  localparam logic [PC_WIDTH-1:0]          START_VAL = PC_WIDTH'(START_PC);
  localparam logic [THREAD_ADDR_WIDTH-1:0] INIT_THR  = THREAD_ADDR_WIDTH'(INITIAL_THREAD);
  localparam logic [THREAD_ADDR_WIDTH-1:0] LAST_THR  = THREAD_ADDR_WIDTH'(THREAD_COUNT - 1);
  localparam logic [THREAD_ADDR_WIDTH-1:0] WARM_LAST = THREAD_ADDR_WIDTH'(THREAD_COUNT - 2);

  typedef enum logic {WARM, RUN} state_t;

  state_t                         state;
  state_t                         state_next;
  logic [THREAD_ADDR_WIDTH-1:0]   warm_cnt;
  logic                           force_start;

  logic [PC_WIDTH-1:0]            ring [THREAD_COUNT-1];
  logic [PC_WIDTH-1:0]            returning;
  logic [PC_WIDTH-1:0]            pc_next;
  logic                           reissue_next;
  logic [THREAD_ADDR_WIDTH-1:0]   thread_next;

  // After reset the ring holds placeholders, not real issues: every thread first issues START_PC once.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= WARM;
      warm_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == WARM)
        warm_cnt <= warm_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == WARM && warm_cnt == WARM_LAST)
      state_next = RUN;
  end

  always_comb begin
    force_start = (state == WARM);
  end

  assign returning   = ring[THREAD_COUNT-2];
  assign thread_next = (thread == LAST_THR) ? '0 : thread + 1'b1;

  // An incomplete instruction wins over any branch decided for it.
  always_comb begin
    pc_next      = returning + 1'b1;
    reissue_next = 1'b0;
    if (force_start) begin
      pc_next = START_VAL;
    end else if (!IO_ready) begin
      pc_next      = returning;
      reissue_next = 1'b1;
    end else if (jump) begin
      pc_next = branch_destination;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      PC      <= START_VAL;
      thread  <= INIT_THR;
      reissue <= 1'b0;
      for (int i = 0; i < THREAD_COUNT-1; i++)
        ring[i] <= START_VAL;
    end else begin
      PC      <= pc_next;
      thread  <= thread_next;
      reissue <= reissue_next;
      ring[0] <= PC;
      for (int i = 1; i < THREAD_COUNT-1; i++)
        ring[i] <= ring[i-1];
    end
  end

endmodule

// File: tb/tb_thread_pc_controller.sv
// Bench for thread_pc_controller: directed scenarios then random traffic, against a per-thread PC model.
module tb_thread_pc_controller;

  localparam int N = 8;

  logic       clock;
  logic       reset;
  logic       jump;
  logic [9:0] branch_destination;
  logic       IO_ready;
  logic [9:0] PC;
  logic [2:0] thread;
  logic       reissue;

  int checks = 0;
  int errors = 0;

  // Model: last PC each thread issued, plus the expected current issue.
  int exp_pc, exp_thr, exp_re, warm;
  int last_pc [N];

  // Per-thread constant expectations for the directed scenarios.
  bit cpend [N];
  int cpc [N];
  int cre [N];

  bit done28, done29, done29b, done30, done31, done31b;

  thread_pc_controller #(
    .PC_WIDTH(10), .THREAD_COUNT(8), .THREAD_ADDR_WIDTH(3),
    .INITIAL_THREAD(0), .START_PC(0)
  ) dut (
    .clock(clock), .reset(reset), .jump(jump),
    .branch_destination(branch_destination), .IO_ready(IO_ready),
    .PC(PC), .thread(thread), .reissue(reissue)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_edge(input logic r, input logic j, input logic [9:0] d, input logic io);
    int nt, np, nr, p;
    if (r) begin
      exp_pc = 0; exp_thr = 0; exp_re = 0; warm = 0;
      foreach (last_pc[i]) last_pc[i] = 0;
      foreach (cpend[i]) cpend[i] = 0;
    end else begin
      nt = (exp_thr + 1) % N;
      if (warm < N-1) begin
        np = 0; nr = 0; warm++;
      end else begin
        p = last_pc[nt];
        if (!io)     begin np = p;               nr = 1; end
        else if (j)  begin np = int'(d);          nr = 0; end
        else         begin np = (p + 1) % 1024;  nr = 0; end
      end
      last_pc[nt] = np;
      exp_pc = np; exp_thr = nt; exp_re = nr;
    end
  endtask

  task automatic step(input logic r, input logic j, input logic [9:0] d, input logic io);
    reset = r; jump = j; branch_destination = d; IO_ready = io;
    @(posedge clock);
    #1;
    model_edge(r, j, d, io);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_pc"}, PC, exp_pc);
    chk({tag, "_thread"}, thread, exp_thr);
    chk({tag, "_reissue"}, reissue, exp_re);
  endtask

  initial begin
    int r, p;
    logic j, io, rr;
    logic [9:0] d;

    clock = 0; reset = 1; jump = 0; branch_destination = 0; IO_ready = 1;

    // Reset, with garbage inputs during reset that must be ignored.
    step(1, 0, 10'h000, 1);
    step(1, 1, 10'h1AA, 0);
    check_model("reset");
    chk("reset_pc_const", PC, 0);
    chk("reset_thread_const", thread, 0);
    chk("reset_reissue_const", reissue, 0);

    // Directed scenarios, triggered by which thread is returning with which PC.
    for (int k = 0; k < 100; k++) begin
      if (k < 24) begin
        chk("start_pc", PC, k / 8);
        chk("start_thread", thread, k % 8);
        chk("start_reissue", reissue, 0);
      end
      r = (exp_thr + 1) % N;
      p = last_pc[r];
      j = 0; d = 0; io = 1;
      if (k >= 24 && r == 3 && !done28) begin
        j = 1; d = 10'h155;
        cpend[3] = 1; cpc[3] = 'h155; cre[3] = 0; done28 = 1;
      end else if (k >= 24 && r == 5 && p == 4 && !done29) begin
        io = 0;
        cpend[5] = 1; cpc[5] = 4; cre[5] = 1; done29 = 1;
      end else if (r == 5 && p == 4 && done29 && !done29b) begin
        cpend[5] = 1; cpc[5] = 5; cre[5] = 0; done29b = 1;
      end else if (k >= 24 && r == 2 && p == 7 && !done30) begin
        j = 1; d = 10'h2AA; io = 0;
        cpend[2] = 1; cpc[2] = 7; cre[2] = 1; done30 = 1;
      end else if (k >= 70 && r == 1 && !done31) begin
        j = 1; d = 10'h3FF;
        cpend[1] = 1; cpc[1] = 'h3FF; cre[1] = 0; done31 = 1;
      end else if (r == 1 && done31 && p == 'h3FF && !done31b) begin
        cpend[1] = 1; cpc[1] = 0; cre[1] = 0; done31b = 1;
      end
      step(0, j, d, io);
      check_model("directed");
      if (cpend[exp_thr]) begin
        chk("scenario_pc", PC, cpc[exp_thr]);
        chk("scenario_reissue", reissue, cre[exp_thr]);
        cpend[exp_thr] = 0;
      end
    end
    chk("covered_jump_t3", done28, 1);
    chk("covered_reissue_t5", done29b, 1);
    chk("covered_jump_vs_io_t2", done30, 1);
    chk("covered_wrap_t1", done31b, 1);

    // 20 running cycles, then a 1-cycle reset carrying a jump that must never land.
    for (int k = 0; k < 20; k++) begin
      j  = ($urandom_range(0, 2) == 0);
      d  = j ? 10'($urandom) : 10'h000;
      io = ($urandom_range(0, 3) != 0);
      step(0, j, d, io);
      check_model("pre_reset");
    end
    step(1, 1, 10'h2BC, 1);
    chk("midreset_pc", PC, 0);
    chk("midreset_thread", thread, 0);
    chk("midreset_reissue", reissue, 0);
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 10'h000, 1);
      check_model("post_reset");
      chk("no_stale_target", (PC !== 10'h2BC), 1);
    end

    // Random traffic with occasional resets; start-up window kept quiet.
    for (int k = 0; k < 400; k++) begin
      rr = ($urandom_range(0, 49) == 0);
      if (warm < N-1) begin
        j = 0; d = 0; io = 1;
      end else begin
        j  = ($urandom_range(0, 2) == 0);
        d  = j ? 10'($urandom) : 10'h000;
        io = ($urandom_range(0, 3) != 0);
      end
      step(rr, j, d, io);
      check_model("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
